// File: rtl/uart_node_arbiter_if.sv
// Bundle of node-link and UART-driver signals around the node arbiter.
// The master side drives node commands and driver returns; the slave side is the arbiter.
`timescale 1ns/1ps
interface uart_node_arbiter_if;
   logic [15:0] in_op_node0;
   logic [15:0] in_op_node1;
   logic [7:0]  in_peripheral;
   logic [1:0]  irq_req;
   logic [7:0]  out_peripheral;
   logic [15:0] out_node;
   logic        periph_en;
   logic [1:0]  grant;
   logic        timeout;
   logic        out_IRQ_node0;
   logic        out_IRQ_node1;

   modport master (
      output in_op_node0, in_op_node1, in_peripheral, irq_req,
      input  out_peripheral, out_node, periph_en, grant, timeout,
             out_IRQ_node0, out_IRQ_node1
   );

   modport slave (
      input  in_op_node0, in_op_node1, in_peripheral, irq_req,
      output out_peripheral, out_node, periph_en, grant, timeout,
             out_IRQ_node0, out_IRQ_node1
   );
endinterface

// File: rtl/uart_node_arbiter.sv
// Arbitrates one UART driver between node 0 and node 1. Ownership is taken with a start
// frame (or a peripheral IRQ request), held until a stop frame or watchdog expiry, and
// every output is registered.
`timescale 1ns/1ps
module uart_node_arbiter #(
   parameter logic [3:0]  TAG      = 4'hB,
   parameter logic [7:0]  IRQ_CODE = 8'd78,
   parameter int unsigned TIMEOUT  = 1000,
   parameter int unsigned TO_W     = 16
) (
   input logic               CLK,
   input logic               RST,
   uart_node_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

   localparam logic [11:0]     START_HI  = {4'hF, TAG, 4'h0};
   localparam logic [15:0]     STOP_WORD = {4'hF, TAG, 8'hFF};
   localparam bit              WD_EN     = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

   // A start frame needs an exact header and a nonzero priority.
   function automatic logic is_start(input logic [15:0] w);
      return (w[15:4] == START_HI) && (w[3:0] != 4'h0);
   endfunction

   state_t          state_q, state_d;
   logic            owner_q, owner_d;      // 0 = node0, 1 = node1
   logic            last_q, last_d;        // previous owner, for round-robin ties
   logic [TO_W-1:0] timer_q, timer_d;
   logic [7:0]      per_q, per_d;
   logic [15:0]     node_q, node_d;
   logic            en_q, en_d;
   logic [1:0]      grant_q, grant_d;
   logic            to_q, to_d;
   logic            irq0_q, irq0_d;
   logic            irq1_q, irq1_d;

   logic            start0, start1, req, pick;
   logic [15:0]     word;

   // Next-state and next-output logic for the IDLE / OWN / RELEASE arbiter.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch can be inferred.
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      timer_d = timer_q;
      per_d   = per_q;
      node_d  = node_q;
      en_d    = en_q;
      grant_d = grant_q;
      to_d    = 1'b0;
      irq0_d  = irq0_q;
      irq1_d  = irq1_q;
      start0  = is_start(bus.in_op_node0);
      start1  = is_start(bus.in_op_node1);
      req     = 1'b0;
      pick    = 1'b0;
      word    = owner_q ? bus.in_op_node1 : bus.in_op_node0;

      case (state_q)
         IDLE: begin
            // Peripheral IRQ requests take precedence over start frames.
            if (bus.irq_req != 2'b00) begin
               req  = 1'b1;
               pick = (bus.irq_req == 2'b11) ? ~last_q : bus.irq_req[1];
            end else if (start0 && start1) begin
               req = 1'b1;
               if (bus.in_op_node0[3:0] > bus.in_op_node1[3:0])      pick = 1'b0;
               else if (bus.in_op_node1[3:0] > bus.in_op_node0[3:0]) pick = 1'b1;
               else                                                  pick = ~last_q;
            end else if (start0 || start1) begin
               req  = 1'b1;
               pick = start1;
            end
            per_d   = 8'h00;
            node_d  = 16'h0000;
            irq0_d  = 1'b0;
            irq1_d  = 1'b0;
            en_d    = 1'b0;
            grant_d = 2'b00;
            if (req) begin
               state_d = OWN;
               owner_d = pick;
               grant_d = pick ? 2'b10 : 2'b01;
               en_d    = 1'b1;
               timer_d = '0;
            end
         end

         OWN: begin
            if (word == STOP_WORD) begin
               state_d = RELEASE;
            end else if (word != 16'h0000 && !is_start(word)) begin
               per_d   = word[7:0];
               node_d  = {(owner_q ? 8'h02 : 8'h01), bus.in_peripheral};
               irq0_d  = !owner_q && (bus.in_peripheral == IRQ_CODE);
               irq1_d  = owner_q && (bus.in_peripheral == IRQ_CODE);
               timer_d = '0;
            end else begin
               // Zero words and re-requests are idle cycles for the watchdog.
               irq0_d  = 1'b0;
               irq1_d  = 1'b0;
               timer_d = timer_q + TO_W'(1);
               if (WD_EN && timer_q == TO_LAST) begin
                  state_d = RELEASE;
                  to_d    = 1'b1;
               end
            end
            if (state_d == RELEASE) begin
               per_d   = 8'h00;
               node_d  = 16'h0000;
               irq0_d  = 1'b0;
               irq1_d  = 1'b0;
               en_d    = 1'b0;
               grant_d = 2'b00;
               timer_d = '0;
            end
         end

         RELEASE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (RST) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         timer_q <= '0;
         per_q   <= 8'h00;
         node_q  <= 16'h0000;
         en_q    <= 1'b0;
         grant_q <= 2'b00;
         to_q    <= 1'b0;
         irq0_q  <= 1'b0;
         irq1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         per_q   <= per_d;
         node_q  <= node_d;
         en_q    <= en_d;
         grant_q <= grant_d;
         to_q    <= to_d;
         irq0_q  <= irq0_d;
         irq1_q  <= irq1_d;
      end
   end

   assign bus.out_peripheral = per_q;
   assign bus.out_node       = node_q;
   assign bus.periph_en      = en_q;
   assign bus.grant          = grant_q;
   assign bus.timeout        = to_q;
   assign bus.out_IRQ_node0  = irq0_q;
   assign bus.out_IRQ_node1  = irq1_q;

endmodule

// File: tb/tb_uart_node_arbiter.sv
// Scoreboard bench for uart_node_arbiter: the driver pushes the hand-computed output
// snapshot expected after each clock edge, and a monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_uart_node_arbiter;

   typedef struct packed {
      logic [1:0]  grant;
      logic        en;
      logic        to;
      logic        i0;
      logic        i1;
      logic [7:0]  per;
      logic [15:0] node;
   } exp_t;

   typedef struct {
      string name;
      exp_t  exp;
   } item_t;

   localparam exp_t Z = '0;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   failures = 0;
   item_t sb_q[$];

   uart_node_arbiter_if bus();

   uart_node_arbiter #(.TIMEOUT(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t e(input logic [1:0] g, input logic en, input logic to,
                              input logic i0, input logic i1, input logic [7:0] per,
                              input logic [15:0] node);
      exp_t r;
      r.grant = g; r.en = en; r.to = to; r.i0 = i0; r.i1 = i1; r.per = per; r.node = node;
      return r;
   endfunction

   // Drive one cycle of inputs and record what the outputs must be after the next edge.
   task automatic step(input string nm, input logic rst, input logic [15:0] o0,
                       input logic [15:0] o1, input logic [7:0] p, input logic [1:0] irq,
                       input exp_t ex);
      item_t it;
      @(negedge CLK);
      RST               = rst;
      bus.in_op_node0   = o0;
      bus.in_op_node1   = o1;
      bus.in_peripheral = p;
      bus.irq_req       = irq;
      it.name = nm;
      it.exp  = ex;
      sb_q.push_back(it);
   endtask

   // Monitor: one registered snapshot per edge, compared against the oldest expectation.
   initial begin
      item_t it;
      exp_t  act;
      forever begin
         @(posedge CLK);
         #1;
         if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            act.grant = bus.grant;
            act.en    = bus.periph_en;
            act.to    = bus.timeout;
            act.i0    = bus.out_IRQ_node0;
            act.i1    = bus.out_IRQ_node1;
            act.per   = bus.out_peripheral;
            act.node  = bus.out_node;
            checks++;
            if (act !== it.exp) begin
               failures++;
               $display("FAIL %s: got grant=%b en=%b to=%b irq=%b%b per=%h node=%h, want grant=%b en=%b to=%b irq=%b%b per=%h node=%h",
                        it.name, act.grant, act.en, act.to, act.i1, act.i0, act.per, act.node,
                        it.exp.grant, it.exp.en, it.exp.to, it.exp.i1, it.exp.i0,
                        it.exp.per, it.exp.node);
            end
         end
      end
   end

   initial begin
      bus.in_op_node0   = 16'h0000;
      bus.in_op_node1   = 16'h0000;
      bus.in_peripheral = 8'h00;
      bus.irq_req       = 2'b00;

      // Reset state.
      step("reset_a", 1, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);
      step("reset_b", 1, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // Single start from node0, then data forwarding and hold on a zero word.
      step("t1_grant", 0, 16'hFB05, 16'h0000, 8'h00, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t1_data",  0, 16'h0041, 16'h0000, 8'h33, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h41, 16'h0133));
      step("t1_hold",  0, 16'h0000, 16'h0000, 8'h99, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h41, 16'h0133));
      step("t1_stop",  0, 16'hFBFF, 16'h0000, 8'h00, 2'b00, Z);
      step("t1_rel",   0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // Priority: node1 at 9 beats node0 at 3; then equal priorities go round-robin.
      step("t2_prio",  0, 16'hFB03, 16'hFB09, 8'h00, 2'b00, e(2'b10, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t2_stop",  0, 16'h0000, 16'hFBFF, 8'h00, 2'b00, Z);
      step("t2_rel",   0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);
      step("t2_rr",    0, 16'hFB05, 16'hFB05, 8'h00, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h00, 16'h0000));

      // IRQ code from the peripheral raises only the owner's IRQ, for that cycle only.
      step("t3_irq",   0, 16'h0042, 16'h0000, 8'h4E, 2'b00, e(2'b01, 1, 0, 1, 0, 8'h42, 16'h014E));
      step("t3_clr",   0, 16'h0043, 16'h0000, 8'h4D, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h43, 16'h014D));
      step("t3_stop",  0, 16'hFBFF, 16'h0000, 8'h00, 2'b00, Z);
      step("t3_rel",   0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // Watchdog with TIMEOUT = 8: seven idle cycles stay owned, the eighth releases.
      step("t4_grant", 0, 16'h0000, 16'hFB02, 8'h00, 2'b00, e(2'b10, 1, 0, 0, 0, 8'h00, 16'h0000));
      for (int i = 0; i < 7; i++)
         step("t4_idle", 0, 16'h0000, 16'h0000, 8'h00, 2'b00, e(2'b10, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t4_timeout", 0, 16'h0000, 16'h0000, 8'h00, 2'b00, e(2'b00, 0, 1, 0, 0, 8'h00, 16'h0000));
      step("t4_rel",     0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);
      step("t4_idle_st", 0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // IRQ request beats a top-priority start; non-owner traffic and irq_req are ignored.
      step("t5_irq_grant", 0, 16'hFB0F, 16'h0000, 8'h00, 2'b10, e(2'b10, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t5_data",      0, 16'h0066, 16'h0055, 8'h4E, 2'b01, e(2'b10, 1, 0, 0, 1, 8'h55, 16'h024E));

      // Reset while data flows, then a normal new grant.
      step("t6_reset",   1, 16'h0000, 16'h0056, 8'h11, 2'b00, Z);
      step("t6_regrant", 0, 16'hFB01, 16'h0000, 8'h00, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t6_data",    0, 16'h0077, 16'h0000, 8'h00, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h77, 16'h0100));

      // Stop on the same cycle the watchdog would expire: released without a timeout pulse.
      for (int i = 0; i < 7; i++)
         step("t7_idle", 0, 16'h0000, 16'h0000, 8'h00, 2'b00, e(2'b01, 1, 0, 0, 0, 8'h77, 16'h0100));
      step("t7_stop_wins", 0, 16'hFBFF, 16'h0000, 8'h00, 2'b00, Z);
      step("t7_rel",       0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // Malformed frames are not requests: prty 0, nonzero bits [7:4], wrong tag.
      step("t8_prty0",  0, 16'hFB00, 16'hFB15, 8'h00, 2'b00, Z);
      step("t8_badtag", 0, 16'hFA05, 16'h0000, 8'h00, 2'b00, Z);

      // Both IRQ bits after node0 owned last: node1 wins the tie.
      step("t9_irq_tie", 0, 16'h0000, 16'h0000, 8'h00, 2'b11, e(2'b10, 1, 0, 0, 0, 8'h00, 16'h0000));
      step("t9_stop",    0, 16'h0000, 16'hFBFF, 8'h00, 2'b00, Z);
      step("t9_rel",     0, 16'h0000, 16'h0000, 8'h00, 2'b00, Z);

      // Let the monitor drain the scoreboard, with a bounded wait.
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
         @(posedge CLK);
         #2;
      end
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
